// File: rtl/ipif_single_master_pkg.sv
// Shared definitions for the single-beat IPIF master: FSM states and the
// active-low handshake levels used on the IPIC side.
package ipif_single_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } mst_state_e;

    localparam logic IPIF_ASSERT_N   = 1'b0;
    localparam logic IPIF_DEASSERT_N = 1'b1;

endpackage

// File: rtl/ipif_single_master_timeout.sv
// Watchdog for the IPIF master: cleared on load, counts enabled cycles,
// flags the cycle in which the C_LIMIT-th enabled cycle is reached.
module ipif_single_master_timeout #(
    parameter int C_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(C_LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = en && (cnt_q == CW'(C_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ipif_single_master.sv
// Single-beat IPIF bus master, one outstanding transaction.
// Optional watchdog abort of stalled transfers under MST_TIMEOUT_EN.
module ipif_single_master
    import ipif_single_master_pkg::*;
#(
    parameter int C_MST_AWIDTH  = 32,
    parameter int C_MST_DWIDTH  = 32,
    parameter int C_TIMEOUT_CYC = 255
) (
    input  logic                      Bus2IP_Clk,
    input  logic                      Bus2IP_Reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [C_MST_AWIDTH-1:0]   cmd_addr,
    input  logic [C_MST_DWIDTH/8-1:0] cmd_be,
    input  logic [C_MST_DWIDTH-1:0]   cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [C_MST_DWIDTH-1:0]   rsp_rdata,
    output logic                      rsp_err,
    output logic                      IP2Bus_MstRd_Req,
    output logic                      IP2Bus_MstWr_Req,
    output logic [C_MST_AWIDTH-1:0]   IP2Bus_Mst_Addr,
    output logic [C_MST_DWIDTH/8-1:0] IP2Bus_Mst_BE,
    input  logic                      Bus2IP_Mst_CmdAck,
    input  logic                      Bus2IP_Mst_Cmplt,
    input  logic                      Bus2IP_Mst_Error,
    input  logic [C_MST_DWIDTH-1:0]   Bus2IP_MstRd_d,
    input  logic                      Bus2IP_MstRd_src_rdy_n,
    output logic                      IP2Bus_MstRd_dst_rdy_n,
    output logic [C_MST_DWIDTH-1:0]   IP2Bus_MstWr_d,
    output logic                      IP2Bus_MstWr_src_rdy_n,
    input  logic                      Bus2IP_MstWr_dst_rdy_n
);

    localparam int BW = C_MST_DWIDTH / 8;

    mst_state_e state_q, state_d;
    logic                    init_q, init_d;
    logic                    wr_q, wr_d;
    logic [C_MST_AWIDTH-1:0] addr_q, addr_d;
    logic [BW-1:0]           be_q, be_d;
    logic [C_MST_DWIDTH-1:0] wdata_q, wdata_d;
    logic [C_MST_DWIDTH-1:0] data_q, data_d;
    logic                    got_q, got_d;
    logic                    wdone_q, wdone_d;
    logic [C_MST_DWIDTH-1:0] rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic busy, live, accept, beat, wr_take, tmo;

    assign busy    = (state_q == ST_REQ) || (state_q == ST_DATA);
    // Data phase opens in the cycle the request is acknowledged.
    assign live    = (state_q == ST_DATA)
                  || ((state_q == ST_REQ) && Bus2IP_Mst_CmdAck);
    assign accept  = cmd_valid && cmd_ready;
    assign beat    = live && !wr_q && !got_q
                  && (Bus2IP_MstRd_src_rdy_n == IPIF_ASSERT_N);
    assign wr_take = live && wr_q && !wdone_q
                  && (Bus2IP_MstWr_dst_rdy_n == IPIF_ASSERT_N);

`ifdef MST_TIMEOUT_EN
    ipif_single_master_timeout #(
        .C_LIMIT (C_TIMEOUT_CYC)
    ) u_timeout (
        .clk     (Bus2IP_Clk),
        .rst     (Bus2IP_Reset),
        .load    (accept),
        .en      (busy),
        .expired (tmo)
    );
`else
    // No watchdog in this build: wait for the slave indefinitely.
    assign tmo = 1'b0 & (C_TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_REQ;
            ST_REQ: begin
                if (Bus2IP_Mst_Cmplt || tmo) begin
                    state_d = ST_RESP;
                end else if (Bus2IP_Mst_CmdAck) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: if (Bus2IP_Mst_Cmplt || tmo) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready              = (state_q == ST_IDLE) && init_q;
        rsp_valid              = (state_q == ST_RESP);
        IP2Bus_MstRd_Req       = (state_q == ST_REQ) && !wr_q;
        IP2Bus_MstWr_Req       = (state_q == ST_REQ) && wr_q;
        IP2Bus_MstRd_dst_rdy_n = (live && !wr_q) ? IPIF_ASSERT_N
                                                 : IPIF_DEASSERT_N;
        IP2Bus_MstWr_src_rdy_n = (live && wr_q && !wdone_q) ? IPIF_ASSERT_N
                                                            : IPIF_DEASSERT_N;
    end

    always_comb begin
        init_d  = 1'b1;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        got_d   = got_q;
        wdone_d = wdone_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            wr_d    = cmd_wr;
            addr_d  = cmd_addr;
            be_d    = cmd_be;
            wdata_d = cmd_wdata;
            data_d  = '0;
            got_d   = 1'b0;
            wdone_d = 1'b0;
        end
        if (beat) begin
            data_d = Bus2IP_MstRd_d;
            got_d  = 1'b1;
        end
        if (wr_take) wdone_d = 1'b1;
        // Completion wins over a same-cycle watchdog expiry.
        if (busy && Bus2IP_Mst_Cmplt) begin
            rdata_d = (!wr_q && got_d) ? data_d : '0;
            err_d   = Bus2IP_Mst_Error || (!wr_q && !got_d);
        end else if (busy && tmo) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            init_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            got_q   <= 1'b0;
            wdone_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            init_q  <= init_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            got_q   <= got_d;
            wdone_q <= wdone_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign IP2Bus_Mst_Addr = addr_q;
    assign IP2Bus_Mst_BE   = be_q;
    assign IP2Bus_MstWr_d  = wdata_q;
    assign rsp_rdata       = rdata_q;
    assign rsp_err         = err_q;

endmodule

// File: tb/tb_ipif_single_master.sv
// Directed plus randomized bench for ipif_single_master with a cycle-level
// IPIC slave driven from one sequence and a transaction-level reference.
module tb_ipif_single_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_be = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rd_req, wr_req;
    logic [31:0] mst_addr;
    logic [3:0]  mst_be;
    logic        cmdack = 1'b0;
    logic        cmplt = 1'b0;
    logic        merr = 1'b0;
    logic [31:0] rd_d = '0;
    logic        rd_src_rdy_n = 1'b1;
    logic        rd_dst_rdy_n;
    logic [31:0] wr_d;
    logic        wr_src_rdy_n;
    logic        wr_dst_rdy_n = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ipif_single_master #(
        .C_MST_AWIDTH (32),
        .C_MST_DWIDTH (32),
        .C_TIMEOUT_CYC(TMO)
    ) dut (
        .Bus2IP_Clk             (clk),
        .Bus2IP_Reset           (rst),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_wr                 (cmd_wr),
        .cmd_addr               (cmd_addr),
        .cmd_be                 (cmd_be),
        .cmd_wdata              (cmd_wdata),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_rdata              (rsp_rdata),
        .rsp_err                (rsp_err),
        .IP2Bus_MstRd_Req       (rd_req),
        .IP2Bus_MstWr_Req       (wr_req),
        .IP2Bus_Mst_Addr        (mst_addr),
        .IP2Bus_Mst_BE          (mst_be),
        .Bus2IP_Mst_CmdAck      (cmdack),
        .Bus2IP_Mst_Cmplt       (cmplt),
        .Bus2IP_Mst_Error       (merr),
        .Bus2IP_MstRd_d         (rd_d),
        .Bus2IP_MstRd_src_rdy_n (rd_src_rdy_n),
        .IP2Bus_MstRd_dst_rdy_n (rd_dst_rdy_n),
        .IP2Bus_MstWr_d         (wr_d),
        .IP2Bus_MstWr_src_rdy_n (wr_src_rdy_n),
        .Bus2IP_MstWr_dst_rdy_n (wr_dst_rdy_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        cmdack       = 1'b0;
        cmplt        = 1'b0;
        merr         = 1'b0;
        rd_src_rdy_n = 1'b1;
        wr_dst_rdy_n = 1'b1;
    endtask

    task automatic present(input logic wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_be    = be;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_be    = 4'($urandom);
        cmd_wdata = $urandom;
        cmd_wr    = ~wr;
    endtask

    task automatic finish_resp(input logic [31:0] er, input logic ee,
                               input int hold);
        chk("rsp_valid", 32'(rsp_valid), 32'(1));
        chk("rsp_rdata", rsp_rdata, er);
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'(1));
            chk("hold_rdata", rsp_rdata, er);
            chk("hold_err", 32'(rsp_err), 32'(ee));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("post_cmd_ready", 32'(cmd_ready), 32'(1));
    endtask

    // ack: cycles of Req before CmdAck; cpl: cycles from CmdAck to Cmplt;
    // ddly: read beat offset from CmdAck (-1 none); wdly: write take offset.
    task automatic txn(input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] rv, input int ack, input int cpl,
                       input int ddly, input int wdly, input logic err,
                       input int hold);
        logic        got;
        logic [31:0] er;
        logic        ee;
        int          reqc;
        got  = !wr && ddly >= 0 && ddly <= cpl;
        er   = got ? rv : 32'h0;
        ee   = err || (!wr && !got);
        reqc = 0;
        present(wr, a, be, wd);
        for (int c = 0; c <= ack + cpl; c++) begin
            if (wr ? wr_req : rd_req) reqc++;
            chk("other_req", 32'(wr ? rd_req : wr_req), 32'(0));
            if (c == 0) begin
                chk("mst_addr", mst_addr, a);
                chk("mst_be", 32'(mst_be), 32'(be));
            end
            cmdack       = (c == ack);
            cmplt        = (c == ack + cpl);
            merr         = (c == ack + cpl) ? err : 1'b0;
            rd_src_rdy_n = !(!wr && ddly >= 0 && c == ack + ddly);
            rd_d         = rd_src_rdy_n ? $urandom : rv;
            wr_dst_rdy_n = !(wr && c == ack + wdly);
            #1;
            if (wr && c >= ack && c <= ack + wdly) begin
                chk("wr_src_rdy", 32'(wr_src_rdy_n), 32'(0));
                chk("wr_data", wr_d, wd);
            end
            if (wr && c > ack + wdly)
                chk("wr_src_done", 32'(wr_src_rdy_n), 32'(1));
            if (!wr && c >= ack)
                chk("rd_dst_rdy", 32'(rd_dst_rdy_n), 32'(0));
            @(negedge clk);
        end
        slave_idle();
        chk("req_cycles", 32'(reqc), 32'(ack + 1));
        finish_resp(er, ee, hold);
    endtask

    initial begin
        int cpl, ddly;
        int reqc;
        logic w;

        // reset state
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_req", 32'({rd_req, wr_req}), 32'(0));
        chk("rst_addr", mst_addr, 32'h0);
        chk("rst_rdy_n", 32'({rd_dst_rdy_n, wr_src_rdy_n}), 32'(3));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'(0));

        // directed scenarios
        txn(1'b1, 32'h0, 4'hF, 32'h000000A5, 32'h0, 2, 1, -1, 0, 1'b0, 0);
        txn(1'b0, 32'h4, 4'hF, 32'h0, 32'h0000005A, 1, 3, 3, 0, 1'b0, 0);
        txn(1'b0, 32'h8, 4'h3, 32'h0, 32'h00000012, 0, 0, 0, 0, 1'b0, 0);
        txn(1'b0, 32'hC, 4'hF, 32'h0, 32'h00000077, 0, 1, 1, 0, 1'b1, 5);
        txn(1'b0, 32'h10, 4'hF, 32'h0, 32'h00000033, 1, 2, -1, 0, 1'b0, 0);

        // slave never acknowledges
        present(1'b0, 32'h20, 4'hF, 32'h0);
        reqc = 0;
`ifdef MST_TIMEOUT_EN
        for (int c = 0; c < TMO; c++) begin
            if (rd_req) reqc++;
            @(negedge clk);
        end
        chk("tmo_req_cycles", 32'(reqc), 32'(TMO));
        chk("tmo_req_drop", 32'(rd_req), 32'(0));
        finish_resp(32'h0, 1'b1, 0);
`else
        for (int c = 0; c < 3 * TMO; c++) @(negedge clk);
        chk("no_tmo_req", 32'(rd_req), 32'(1));
        chk("no_tmo_valid", 32'(rsp_valid), 32'(0));
        cmdack = 1'b1;
        cmplt  = 1'b1;
        @(negedge clk);
        slave_idle();
        finish_resp(32'h0, 1'b1, 0);
`endif

        // reset in REQ drops the request at once
        present(1'b0, 32'h30, 4'hF, 32'h0);
        chk("pre_rst_req", 32'(rd_req), 32'(1));
        rst = 1'b1;
        #1;
        chk("rst_req_drop", 32'(rd_req), 32'(0));
        chk("rst_addr_clr", mst_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // reset in write DATA phase drops write data valid
        present(1'b1, 32'h34, 4'hF, 32'hDEADBEEF);
        cmdack = 1'b1;
        @(negedge clk);
        cmdack = 1'b0;
        chk("data_src_rdy", 32'(wr_src_rdy_n), 32'(0));
        rst = 1'b1;
        #1;
        chk("rst_src_rdy", 32'(wr_src_rdy_n), 32'(1));
        chk("rst_valid", 32'(rsp_valid), 32'(0));
        chk("rst_ready", 32'(cmd_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_valid", 32'(rsp_valid), 32'(0));
        txn(1'b1, 32'h38, 4'hC, 32'h12345678, 32'h0, 1, 1, -1, 1, 1'b0, 0);

        // randomized transactions
        for (int n = 0; n < 30; n++) begin
            w    = 1'($urandom);
            cpl  = int'($urandom_range(0, 3));
            ddly = int'($urandom_range(0, 4)) - 1;
            txn(w, $urandom, 4'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 3)), cpl, ddly,
                int'($urandom_range(0, cpl)),
                ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench time limit");
    end

endmodule
